// File: rtl/prefix_arb_pkg.sv
// Shared definitions for the prefix round-robin arbiter: FSM encoding and
// vector helpers sized for the widest supported requester count.
package prefix_arb_pkg;

    localparam int ARB_MAX_W     = 32;
    localparam int ARB_MAX_IDX_W = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef logic [ARB_MAX_W-1:0]     arb_vec_t;
    typedef logic [ARB_MAX_IDX_W-1:0] arb_idx_t;

    // Applied to a prefix-OR vector, isolates the lowest set bit of the source.
    function automatic arb_vec_t first_one(input arb_vec_t vec);
        return vec & ~(vec << 1);
    endfunction

    function automatic arb_idx_t onehot_to_idx(input arb_vec_t vec);
        arb_idx_t idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            if (vec[i]) begin
                idx = idx | arb_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prefix_or_tree.sv
// Kogge-Stone prefix-OR: bit i of pfx is the OR of vec[i:0], log2 levels deep.
module prefix_or_tree #(
    parameter int p_WIDTH = 10
) (
    input  logic [p_WIDTH-1:0] vec,
    output logic [p_WIDTH-1:0] pfx
);

    localparam int LVLS = (p_WIDTH > 1) ? $clog2(p_WIDTH) : 1;

    for (genvar gi = 0; gi < LVLS; gi++) begin : g_lvl
        logic [p_WIDTH-1:0] lvl_in;
        logic [p_WIDTH-1:0] lvl_out;
        if (gi == 0) begin : g_first
            assign lvl_in = vec;
        end else begin : g_chain
            assign lvl_in = g_lvl[gi-1].lvl_out;
        end
        assign lvl_out = lvl_in | (lvl_in << (1 << gi));
    end

    assign pfx = g_lvl[LVLS-1].lvl_out;

endmodule

// File: rtl/prefix_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, handoff without idle
// bubbles, and a hold limit that forces rotation when others are waiting.
module prefix_rr_arbiter
    import prefix_arb_pkg::*;
#(
    parameter int p_WIDTH    = 10,
    parameter int p_IDX_W    = $clog2(p_WIDTH),
    parameter int p_MAX_HOLD = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [p_WIDTH-1:0]                req,
    output logic [p_WIDTH-1:0]                gnt,
    output logic                              gnt_valid,
    output logic [p_IDX_W-1:0]                gnt_idx,
    output logic [$clog2(p_MAX_HOLD+1)-1:0]   hold_cnt
);

    localparam int HC_W = $clog2(p_MAX_HOLD + 1);
    localparam logic [HC_W-1:0]    HOLD_MAX  = HC_W'(p_MAX_HOLD);
    localparam logic [HC_W-1:0]    HOLD_LIM  = HC_W'(p_MAX_HOLD - 1);
    localparam logic [p_IDX_W-1:0] PTR_RESET = p_IDX_W'(p_WIDTH - 1);

    logic [0:0]         state_reg, state_next;
    logic [p_WIDTH-1:0] gnt_reg, gnt_next;
    logic               gnt_valid_reg, gnt_valid_next;
    logic [p_IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
    logic [p_IDX_W-1:0] ptr_reg, ptr_next;
    logic [HC_W-1:0]    hold_cnt_reg, hold_cnt_next;

    logic               busy;
    logic               holder_released;
    logic               hold_expired;
    logic               rotate;
    logic [p_IDX_W-1:0] sel_ptr;
    logic [p_WIDTH-1:0] others;
    logic [p_WIDTH-1:0] mask;
    logic [p_WIDTH-1:0] req_masked;
    logic [p_WIDTH-1:0] pm, pu;
    arb_vec_t           pm_ext, pu_ext, win_ext;
    arb_idx_t           win_idx_full;
    logic [p_WIDTH-1:0] winner;
    logic [p_IDX_W-1:0] winner_idx;
    logic               unused_bits;

    assign busy = (state_reg == ST_BUSY);

    // While idle gnt_reg is zero, so "others" is simply the full request vector.
    assign others          = req & ~gnt_reg;
    assign holder_released = busy && ((req & gnt_reg) == '0);
    // A saturated holder also yields as soon as anyone else starts asking.
    assign hold_expired    = busy && (hold_cnt_reg >= HOLD_LIM) && (others != '0);
    assign rotate          = holder_released || hold_expired;
    assign sel_ptr         = busy ? gnt_idx_reg : ptr_reg;

    for (genvar gi = 0; gi < p_WIDTH; gi++) begin : g_mask
        localparam logic [p_IDX_W-1:0] BIT_IDX = p_IDX_W'(gi);
        assign mask[gi] = (BIT_IDX > sel_ptr);
    end

    assign req_masked = others & mask;

    prefix_or_tree #(.p_WIDTH(p_WIDTH)) u_pfx_masked (
        .vec (req_masked),
        .pfx (pm)
    );

    prefix_or_tree #(.p_WIDTH(p_WIDTH)) u_pfx_unmasked (
        .vec (others),
        .pfx (pu)
    );

    always_comb begin
        pm_ext = '0;
        pu_ext = '0;
        pm_ext[p_WIDTH-1:0] = pm;
        pu_ext[p_WIDTH-1:0] = pu;
        win_ext      = (req_masked != '0) ? first_one(pm_ext) : first_one(pu_ext);
        win_idx_full = onehot_to_idx(win_ext);
    end

    assign winner      = win_ext[p_WIDTH-1:0];
    assign winner_idx  = win_idx_full[p_IDX_W-1:0];
    assign unused_bits = ^{win_ext, win_idx_full};

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        gnt_idx_next  = gnt_idx_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req != '0) begin
                    state_next    = ST_BUSY;
                    gnt_next      = winner;
                    gnt_idx_next  = winner_idx;
                    hold_cnt_next = '0;
                end
            end
            default: begin
                if (rotate) begin
                    ptr_next      = gnt_idx_reg;
                    gnt_next      = winner;
                    gnt_idx_next  = winner_idx;
                    hold_cnt_next = '0;
                    state_next    = (winner != '0) ? ST_BUSY : ST_IDLE;
                end else if (hold_cnt_reg != HOLD_MAX) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
        endcase
        gnt_valid_next = (gnt_next != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            gnt_idx_reg   <= '0;
            ptr_reg       <= PTR_RESET;
            hold_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gnt_valid_reg <= gnt_valid_next;
            gnt_idx_reg   <= gnt_idx_next;
            ptr_reg       <= ptr_next;
            hold_cnt_reg  <= hold_cnt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_valid = gnt_valid_reg;
    assign gnt_idx   = gnt_idx_reg;
    assign hold_cnt  = hold_cnt_reg;

endmodule
